serial_subtractor: RTL and testbench

- Bit-serial, multi-cycle subtractor. Computes D = A - B - Bin over WIDTH cycles using one full-subtractor cell and a borrow flip-flop, processing the LSB first.
- It is the subtraction counterpart to the team's combinational ripple adders. It is used in area-constrained datapaths where a WIDTH-bit difference can wait WIDTH+1 cycles.
- It uses a start/busy/done handshake toward a controlling FSM.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/fs_cell.sv | 16 +
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter must hold 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
module fs_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  // Difference bit and borrow generated/propagated by this bit position.
  always_comb begin
    o_d    = i_a ^ i_b ^ i_bin;
    o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, LSB first, one bit per cycle using a
// single fs_cell and a borrow flop. Result pulses done WIDTH+1 cycles after start.
// Optional signed-overflow output V is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             o_v
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic [CntW-1:0]  r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic             w_accept;

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_v;
`endif

  fs_cell u_fs_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  assign w_last   = (r_cnt == LastCnt);
  assign w_accept = (r_state == StIdle) && i_start;

  // State register; reset overrides any simultaneous start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StRun;
      end
      StRun: begin
        o_busy = 1'b1;
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand load on accept, then one shift/borrow step per RUN cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_v     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_d    <= '0;
      r_cnt  <= '0;
      r_br   <= i_bin;
      r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb <= i_a[WIDTH-1];
      r_b_msb <= i_b[WIDTH-1];
      r_v     <= 1'b0;
`endif
    end else if (r_state == StRun) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_d   <= {w_d, r_d[WIDTH-1:1]};
      r_br  <= w_bout;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_bout <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
        // w_d is the bit landing in the result MSB on this final edge.
        r_v <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
      end
    end
  end

  assign o_d    = r_d;
  assign o_bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign o_v    = r_v;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 main instance, WIDTH=4 side
// instance). Expected results come from plain integer arithmetic.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         v;

  logic         start4;
  logic [3:0]   a4;
  logic [3:0]   b4;
  logic         bin4;
  logic         busy4;
  logic         done4;
  logic [3:0]   d4;
  logic         bout4;
  logic         v4;

  int total;
  int bad;

  logic [W-1:0] prev_d;
  logic         prev_b;
  logic         prev_v;

  serial_subtractor #(.WIDTH(W)) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_d     (d),
    .o_bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .o_v     (v)
`endif
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start4),
    .i_a     (a4),
    .i_b     (b4),
    .i_bin   (bin4),
    .o_busy  (busy4),
    .o_done  (done4),
    .o_d     (d4),
    .o_bout  (bout4)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .o_v     (v4)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign v  = 1'b0;
  assign v4 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation; hold=1 keeps start high (with junk operands) throughout.
  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       input logic op_bin, input bit hold);
    int           diff;
    logic [W-1:0] exp_d;
    logic         exp_b;
    logic         exp_v;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("hold_d", 32'(d), 32'(prev_d));
    chk("hold_bout", 32'(bout), 32'(prev_b));
`ifdef SERIAL_SUB_OVF_EN
    chk("hold_v", 32'(v), 32'(prev_v));
`endif
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    bin   = op_bin;
    diff  = int'(op_a) - int'(op_b) - int'(op_bin);
    exp_d = diff[W-1:0];
    exp_b = (diff < 0);
    exp_v = (op_a[W-1] != op_b[W-1]) && (exp_d[W-1] != op_a[W-1]);
    for (int k = 1; k <= int'(W); k++) begin
      @(negedge clk);
      chk("run_busy", 32'(busy), 1);
      chk("run_done", 32'(done), 0);
      if (k == 1) begin
        chk("accept_clr_d", 32'(d), 0);
        chk("accept_clr_bout", 32'(bout), 0);
      end
      start = hold;
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("result_d", 32'(d), 32'(exp_d));
    chk("result_bout", 32'(bout), 32'(exp_b));
`ifdef SERIAL_SUB_OVF_EN
    chk("result_v", 32'(v), 32'(exp_v));
`endif
    start  = hold;
    prev_d = exp_d;
    prev_b = exp_b;
    prev_v = exp_v;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    bin4   = 1'b0;
    prev_d = '0;
    prev_b = 1'b0;
    prev_v = 1'b0;

    // Reset, with a start asserted to confirm reset wins.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_d", 32'(d), 0);
    chk("rst_bout", 32'(bout), 0);
    chk("rst_v", 32'(v), 0);
    start = 1'b0;
    rst   = 1'b0;

    // Directed cases.
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8'h10, 8'h0F, 1'b1, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 1'b0);
    do_op(8'h05, 8'h03, 1'b0, 1'b0);
    do_op(8'h00, 8'hFF, 1'b1, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    // start held high: extra starts during RUN/DONE must be ignored.
    do_op(8'hC3, 8'h4E, 1'b0, 1'b1);
    do_op(8'h7F, 8'h80, 1'b1, 1'b0);

    // Abort mid-RUN: no done, outputs cleared.
    @(negedge clk);
    start = 1'b1;
    a     = 8'hA5;
    b     = 8'h11;
    bin   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_d", 32'(d), 0);
    chk("abort_bout", 32'(bout), 0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
    prev_d = '0;
    prev_b = 1'b0;
    prev_v = 1'b0;
    do_op(8'h33, 8'h44, 1'b0, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
    end
    start = 1'b0;

    // WIDTH=4 instance: 3 - 5 = 0xE with borrow, done in cycle 5.
    @(negedge clk);
    start4 = 1'b1;
    a4     = 4'h3;
    b4     = 4'h5;
    bin4   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      chk("w4_busy", 32'(busy4), 1);
      chk("w4_run_done", 32'(done4), 0);
    end
    @(negedge clk);
    chk("w4_done", 32'(done4), 1);
    chk("w4_d", 32'(d4), 32'h0000000E);
    chk("w4_bout", 32'(bout4), 1);
    @(negedge clk);
    chk("w4_done_once", 32'(done4), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
